// File: rtl/key_match_arbiter.sv
// key_match_arbiter
//   Round-robin arbiter that shares one key-match responder among N_REQ
//   requesters. The winner's key is registered and presented to the responder
//   on dn_req/dn_key until dn_ack. The winner then gets a one-cycle done pulse,
//   and the number of WAIT cycles is recorded in last_latency.
//   All outputs decode from registers, so there is no combinational path from
//   dn_ack or req_valid to any output.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   req_valid      per-requester request, held with a stable key until done/err
//   req_key        packed keys, requester i at [i*KEY_W +: KEY_W]
//   done           one-hot, one-cycle match pulse
//   err            one-hot, one-cycle timeout pulse (0 without the timeout)
//   busy           arbiter not in IDLE
//   last_latency   WAIT cycles of last completed transaction, saturating at 31
//   dn_req/dn_key  request and key to the responder
//   dn_ack         responder match (combinational in the responder)
//
// Optional build macro
//   KEY_MATCH_ARB_TIMEOUT_EN : abort WAIT after TIMEOUT_CYC cycles with an err
//                              pulse (DONE_ERR state).
module key_match_arbiter #(
  parameter int N_REQ       = 4,
  parameter int KEY_W       = 4,
  parameter int TIMEOUT_CYC = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*KEY_W-1:0] req_key,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic                   busy,
  output logic [4:0]             last_latency,
  output logic                   dn_req,
  output logic [KEY_W-1:0]       dn_key,
  input  logic                   dn_ack
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  // Elaboration-time parameter range checks.
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("key_match_arbiter: N_REQ must be 2..8");
  end
  if (TIMEOUT_CYC < 1 || KEY_W < 1) begin : g_bad_cfg
    $error("key_match_arbiter: TIMEOUT_CYC and KEY_W must be at least 1");
  end

`ifdef KEY_MATCH_ARB_TIMEOUT_EN
  localparam int         TO_LIMIT = TIMEOUT_CYC - 1;
  localparam logic [4:0] TO_LAT   = (TIMEOUT_CYC > 31) ? 5'd31 : 5'(TIMEOUT_CYC);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
`ifdef KEY_MATCH_ARB_TIMEOUT_EN
    , S_DONE_ERR
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [4:0]       wait_cnt_q, wait_cnt_d;
  logic [4:0]       last_latency_q, last_latency_d;

  // Round-robin pick: first set req_valid bit searching upward from ptr.
  logic             found;
  logic [IDX_W-1:0] sel;
  logic [KEY_W-1:0] sel_key;
  int               idx;

  always_comb begin
    found   = 1'b0;
    sel     = '0;
    sel_key = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        sel     = idx[IDX_W-1:0];
        sel_key = req_key[idx*KEY_W +: KEY_W];
      end
    end
  end

  // wait_cnt + 1 saturating; doubles as the latency recorded on a match
  // since the matching cycle itself counts as a WAIT cycle.
  logic [4:0] wait_inc;
  assign wait_inc = (wait_cnt_q == 5'd31) ? 5'd31 : wait_cnt_q + 5'd1;

  logic [IDX_W-1:0] ptr_next;
  assign ptr_next = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_idx_d      = gnt_idx_q;
    key_d          = key_q;
    wait_cnt_d     = wait_cnt_q;
    last_latency_d = last_latency_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_idx_d  = sel;
          key_d      = sel_key;
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_inc;
        if (dn_ack) begin
          last_latency_d = wait_inc;
          state_d        = S_DONE;
        end
`ifdef KEY_MATCH_ARB_TIMEOUT_EN
        // A match in the final allowed cycle wins over the timeout.
        else if (32'(wait_cnt_q) == 32'(TO_LIMIT)) begin
          last_latency_d = TO_LAT;
          state_d        = S_DONE_ERR;
        end
`endif
      end
      S_DONE: begin
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
`ifdef KEY_MATCH_ARB_TIMEOUT_EN
      S_DONE_ERR: begin
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      gnt_idx_q      <= '0;
      key_q          <= '0;
      wait_cnt_q     <= '0;
      last_latency_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_idx_q      <= gnt_idx_d;
      key_q          <= key_d;
      wait_cnt_q     <= wait_cnt_d;
      last_latency_q <= last_latency_d;
    end
  end

  logic [N_REQ-1:0] gnt_oh;
  assign gnt_oh = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_q;

  assign busy         = (state_q != S_IDLE);
  assign dn_req       = (state_q == S_WAIT);
  assign dn_key       = (state_q == S_IDLE) ? '0 : key_q;
  assign done         = (state_q == S_DONE) ? gnt_oh : '0;
  assign last_latency = last_latency_q;
`ifdef KEY_MATCH_ARB_TIMEOUT_EN
  assign err          = (state_q == S_DONE_ERR) ? gnt_oh : '0;
`else
  assign err          = '0;
`endif

endmodule

// File: doc/key_match_arbiter.md
Name: key_match_arbiter

Overview:
- Shares one key-match responder among N_REQ requesters. The responder uses a req/req_key/ack interface and raises ack combinationally when the presented key equals its free-running down-counter.
- Performs round-robin arbitration and drives the responder with registered req/key, so no combinational path exists from dn_ack to dn_req/dn_key.
- Returns a one-cycle done pulse to the winning requester and records the match latency.
- Sits between client FSMs and the key-match responder in the verification subsystem.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- KEY_W, 4: key width; must equal the responder key width.
- TIMEOUT_CYC, 20: maximum number of WAIT cycles before abort (used only with the optional feature); must be at least 1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  N_REQ  per-requester request; held high with a stable key until that requester's done or err pulse.
- req_key  input  N_REQ*KEY_W  packed keys; requester i uses bits [i*KEY_W +: KEY_W].
- done  output  N_REQ  one-hot, one-cycle pulse: requester's key was matched.
- err  output  N_REQ  one-hot, one-cycle pulse: requester's transaction timed out (constant 0 without the macro).
- busy  output  1  high in any state other than IDLE.
- last_latency  output  5  number of WAIT cycles in the most recently completed transaction, saturating at 31.
- dn_req  output  1  request to the responder.
- dn_key  output  KEY_W  key presented to the responder.
- dn_ack  input  1  responder match indication (combinational in the responder).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All outputs are Moore, decoded from registers only. No output may depend combinationally on dn_ack or req_valid.
- Reset values:
  - state = IDLE, ptr = 0, gnt_idx = 0, key_q = 0, wait_cnt = 0, last_latency = 0.
  - done = 0, err = 0, dn_req = 0, dn_key = 0, busy = 0.
- State IDLE:
  - If any req_valid is high, select the first set bit searching upward from ptr with wrap-around.
  - Latch gnt_idx and key_q, clear wait_cnt, go to WAIT.
  - Otherwise stay in IDLE.
- State WAIT:
  - dn_req = 1, dn_key = key_q; wait_cnt increments each cycle, saturating at 31.
  - If dn_ack is sampled high at the clock edge: last_latency <= wait_cnt + 1 (saturating), go to DONE.
- State DONE (exactly one cycle):
  - done[gnt_idx] = 1, dn_req = 0, dn_key = key_q.
  - ptr <= (gnt_idx + 1) mod N_REQ; go to IDLE.
- Requester obligation: drop req_valid, or present a new key, in the cycle after done. The arbiter samples req_valid again only in IDLE, one cycle after DONE.
- Latency: with req_valid high in cycle 0, dn_req rises in cycle 1. The earliest done is in cycle 2, when dn_ack is high in cycle 1.
- A requester that drops req_valid while in WAIT is a protocol violation. The arbiter ignores it and completes the transaction normally.
- Simultaneous requests are granted strictly in round-robin order; no requester is starved beyond N_REQ-1 other grants.
- rst asserted in any state: all outputs return to their reset values on the next edge. A transaction aborted this way produces no done or err pulse.
- dn_key is 0 while in IDLE.

Optional Feature:
- Macro: KEY_MATCH_ARB_TIMEOUT_EN.
- Defined:
  - In WAIT, when wait_cnt reaches TIMEOUT_CYC-1 and dn_ack is low, go to DONE_ERR. This ends the transaction after TIMEOUT_CYC WAIT cycles.
  - DONE_ERR lasts one cycle: err[gnt_idx] = 1, done = 0, dn_req = 0; last_latency <= TIMEOUT_CYC saturated to 31; ptr advances as in DONE.
  - dn_ack takes priority over timeout in the same cycle.
- Undefined: WAIT holds indefinitely until dn_ack; err is tied to 0; the DONE_ERR state does not exist.

Test Plan:
- Basic match: release rst together with the responder (its counter is 0xF in cycle 0); req_valid[0]=1, key 0xD in cycle 0 -> dn_req=1 in cycles 1-2 with dn_key=0xD; dn_ack in cycle 2; done=4'b0001 in cycle 3 only; last_latency=2; busy low in cycle 4.
- Round-robin: all four req_valid held high with key 0x0, each requester re-asserting after its done -> done pulses in order 0,1,2,3,0; no two done bits ever high together.
- Pointer wrap: after a grant to requester 3, requesters 0 and 2 both valid -> requester 0 granted first.
- Timeout (macro defined, dn_ack tied 0): req_valid[2]=1 -> exactly 20 cycles with dn_req=1, then err=4'b0100 for one cycle, done stays 0, last_latency=20; without the macro -> dn_req stays high and err stays 0 for 100 cycles.
- Reset in WAIT: assert rst for one cycle while dn_req=1 -> next cycle dn_req=0, busy=0, ptr=0, no done or err pulse; a new request is then served normally.
- Latency saturation: responder stub holds dn_ack low for 40 cycles (macro undefined) -> last_latency=31 after done.
